// File: rtl/mult_accumulator.sv
// Accumulates a stream of unsigned 32-bit products into a saturating
// ACC_W-bit sum and hands the total off with a valid/ready handshake.
module mult_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [31:0]      product,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;

    logic               xfer;
    logic [ACC_W:0]     sum;
    logic [CNT_W-1:0]   cnt_inc;

    assign xfer    = (state_q == ACCUM) && prod_valid;
    assign sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, product};
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        len_d   = len;
                        state_d = (len == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        cnt_d = cnt_inc;
                        // Carry out of the top bit means the sum no longer fits
                        if (sum[ACC_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        if (cnt_inc == len_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    assign prod_ready = (state_q == ACCUM);
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign result     = acc_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed scoreboard bench for mult_accumulator (ACC_W=33 to reach
// saturation with 32-bit products).
module tb_mult_accumulator;

    localparam int ACC_W = 33;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [31:0]      product;
    logic             prod_valid;
    logic             prod_ready;
    logic [ACC_W-1:0] result;
    logic             res_valid;
    logic             res_ready;
    logic             overflow;
    logic             busy;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic prev_valid;

    mult_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .start     (start),
        .len       (len),
        .product   (product),
        .prod_valid(prod_valid),
        .prod_ready(prod_ready),
        .result    (result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push(input logic [ACC_W-1:0] r, input logic o);
        exp_t e;
        e.res = r;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Monitor: compare on each new presentation of res_valid
    always @(negedge clk) begin
        if (rst_n && res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got=%0h want=none", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result", 64'(result), 64'(e.res));
                check("sb_overflow", 64'(overflow), 64'(e.ovf));
            end
        end
        prev_valid = res_valid;
    end

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout got=0 want=res_valid");
        end
    endtask

    task automatic issue_start(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int cyc;
        int pat[6];
        int nxt;
        checks     = 0;
        errors     = 0;
        prev_valid = 1'b0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        len        = '0;
        product    = '0;
        prod_valid = 1'b0;
        res_ready  = 1'b1;

        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_ready", 64'(prod_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back len=2, held result until res_ready
        res_ready = 1'b0;
        push(33'd1756896379, 1'b0);
        issue_start(2);
        prod_valid = 1'b1;
        product    = 32'd49;
        @(negedge clk);
        product    = 32'd1756896330;
        @(negedge clk);
        prod_valid = 1'b0;
        check("s1_latency_valid", 64'(res_valid), 64'd1);
        check("s1_ready_low", 64'(prod_ready), 64'd0);
        res_ready = 1'b1;
        @(negedge clk);
        check("s1_idle_valid", 64'(res_valid), 64'd0);
        check("s1_idle_busy", 64'(busy), 64'd0);
        check("s1_held_result", 64'(result), 64'd1756896379);

        // Stalled stream: only valid cycles count
        pat = '{1, 0, 0, 1, 0, 1};
        nxt = 1;
        push(33'd6, 1'b0);
        issue_start(3);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) check("s2_stall_hold", 64'(result), 64'd1);
            prod_valid = pat[i][0];
            product    = pat[i] != 0 ? 32'(nxt) : 32'd99;
            if (pat[i] != 0) nxt++;
            @(negedge clk);
        end
        res_ready  = 1'b0;
        product    = 32'd100;
        prod_valid = 1'b1;
        check("s2_done_ready", 64'(prod_ready), 64'd0);
        @(negedge clk);
        prod_valid = 1'b0;
        check("s2_no_extra", 64'(result), 64'd6);
        res_ready = 1'b1;
        @(negedge clk);

        // len=0 goes straight to DONE and holds
        res_ready = 1'b0;
        push(33'd0, 1'b0);
        issue_start(0);
        check("s3_valid", 64'(res_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3_hold_valid", 64'(res_valid), 64'd1);
            check("s3_hold_result", 64'(result), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);

        // Saturation at 2^33-1, then the next start clears overflow
        push({ACC_W{1'b1}}, 1'b1);
        issue_start(3);
        prod_valid = 1'b1;
        product    = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        prod_valid = 1'b0;
        wait_done(4, cyc);
        @(negedge clk);
        check("s4_ovf_sticky", 64'(overflow), 64'd1);
        push(33'd5, 1'b0);
        issue_start(1);
        check("s4_ovf_cleared", 64'(overflow), 64'd0);
        prod_valid = 1'b1;
        product    = 32'd5;
        @(negedge clk);
        prod_valid = 1'b0;
        wait_done(4, cyc);
        @(negedge clk);

        // Clear after one of four transfers; simultaneous start ignored
        issue_start(4);
        prod_valid = 1'b1;
        product    = 32'd10;
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        len   = 8'd2;
        @(negedge clk);
        clear      = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        check("s5_busy", 64'(busy), 64'd0);
        check("s5_result", 64'(result), 64'd0);
        check("s5_ready", 64'(prod_ready), 64'd0);
        @(negedge clk);
        check("s5_still_idle", 64'(busy), 64'd0);

        // Asynchronous reset between edges, then a fresh run
        issue_start(3);
        prod_valid = 1'b1;
        product    = 32'd9;
        @(posedge clk);
        prod_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_result", 64'(result), 64'd0);
        check("s6_busy", 64'(busy), 64'd0);
        check("s6_ready", 64'(prod_ready), 64'd0);
        check("s6_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(33'd7, 1'b0);
        issue_start(1);
        prod_valid = 1'b1;
        product    = 32'd7;
        @(negedge clk);
        prod_valid = 1'b0;
        wait_done(4, cyc);
        @(negedge clk);
        @(negedge clk);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
